// File: rtl/nibbler_alu_seq.sv
// rtl/nibbler_alu_seq.sv - registered N-bit ALU with iterative MUL/SHL/SHR behind start/busy/done
module nibbler_alu_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] A_Result,
    input  logic [N-1:0] data_bus,
    input  logic         notCarryIn,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         notC,
    output logic         notZ
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT   = CW'(N);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);
    localparam logic [N-1:0]  N_VEC   = N'(N);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_MUL   = 2'b01;
    localparam logic [1:0] S_SHIFT = 2'b10;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   shreg;
    logic           sh_left;

    logic [CW-1:0]  shamt;
    logic [N:0]     a_x;
    logic [N:0]     b_x;
    logic [N:0]     c_x;
    logic [N:0]     alu;
    logic           alu_wr_res;
    logic           alu_wr_flags;
    logic [2*N-1:0] acc_next;
    logic [N-1:0]   sh_next;
    logic           sh_out;

    assign a_x   = {1'b0, A_Result};
    assign b_x   = {1'b0, data_bus};
    assign c_x   = {{N{1'b0}}, ~notCarryIn};
    assign shamt = (data_bus >= N_VEC) ? N_CNT : data_bus[CW-1:0];
    assign busy  = (state != S_IDLE);

    // Single-cycle datapath; bit N of the N+1-bit result is the carry/borrow
    always_comb begin
        alu          = a_x;
        alu_wr_res   = 1'b1;
        alu_wr_flags = 1'b1;
        case (op)
            4'b0000: alu = a_x;
            4'b0001: alu = a_x - b_x;
            4'b0010: alu = b_x;
            4'b0011: alu = a_x + b_x;
            4'b0100: alu = {1'b0, ~(A_Result | data_bus)};
            4'b0101: alu = a_x + b_x + c_x;
            4'b0110: alu = a_x - b_x - c_x;
            4'b0111: begin
                alu        = a_x - b_x;
                alu_wr_res = 1'b0;
            end
            4'b1000, 4'b1001, 4'b1010: alu = a_x;
            default: begin
                alu_wr_res   = 1'b0;
                alu_wr_flags = 1'b0;
            end
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign sh_next  = sh_left ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
    assign sh_out   = sh_left ? shreg[N-1] : shreg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            shreg   <= '0;
            sh_left <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            notC    <= 1'b1;
            notZ    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == 4'b1000) begin
                            state  <= S_MUL;
                            cnt    <= N_CNT;
                            acc    <= '0;
                            mcand  <= {{N{1'b0}}, A_Result};
                            mplier <= data_bus;
                        end else if ((op == 4'b1001 || op == 4'b1010) && shamt != '0) begin
                            state   <= S_SHIFT;
                            cnt     <= shamt;
                            shreg   <= A_Result;
                            sh_left <= (op == 4'b1001);
                        end else begin
                            done <= 1'b1;
                            if (alu_wr_res)
                                result <= alu[N-1:0];
                            if (alu_wr_flags) begin
                                notC <= ~alu[N];
                                notZ <= |alu[N-1:0];
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[2*N-2:0], 1'b0};
                    mplier <= mplier >> 1;
                    cnt    <= cnt - ONE_CNT;
                    // Last partial product lands straight in the result registers
                    if (cnt == ONE_CNT) begin
                        state  <= S_IDLE;
                        done   <= 1'b1;
                        result <= acc_next[N-1:0];
                        notC   <= ~(|acc_next[2*N-1:N]);
                        notZ   <= |acc_next[N-1:0];
                    end
                end
                S_SHIFT: begin
                    shreg <= sh_next;
                    cnt   <= cnt - ONE_CNT;
                    if (cnt == ONE_CNT) begin
                        state  <= S_IDLE;
                        done   <= 1'b1;
                        result <= sh_next;
                        notC   <= ~sh_out;
                        notZ   <= |sh_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibbler_alu_seq.sv
// tb/tb_nibbler_alu_seq.sv - scoreboard bench for nibbler_alu_seq with randomized ops
module tb_nibbler_alu_seq;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         nci;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         notC;
    logic         notZ;

    nibbler_alu_seq #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .A_Result   (a_in),
        .data_bus   (b_in),
        .notCarryIn (nci),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .notC       (notC),
        .notZ       (notZ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int r;
        int nc;
        int nz;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int n_vec  = 0;
    int n_fail = 0;
    int m_r  = 0;
    int m_nc = 1;
    int m_nz = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic; dly = edges after the start edge until done is set
    task automatic model(input int o, input int x, input int y, input int ci,
                         output int r, output int nc, output int nz, output int dly);
        int c;
        int s;
        int full;
        r = m_r; nc = m_nc; nz = m_nz; dly = 0; c = 0;
        s = (y > N) ? N : y;
        case (o)
            0:  begin r = x; c = 0; end
            1:  begin r = (x - y) & MASK; c = (x < y) ? 1 : 0; end
            2:  begin r = y; c = 0; end
            3:  begin full = x + y; r = full & MASK; c = (full > MASK) ? 1 : 0; end
            4:  begin r = (~(x | y)) & MASK; c = 0; end
            5:  begin full = x + y + ci; r = full & MASK; c = (full > MASK) ? 1 : 0; end
            6:  begin full = x - y - ci; r = full & MASK; c = (full < 0) ? 1 : 0; end
            7:  begin full = x - y; c = (full < 0) ? 1 : 0; end
            8:  begin full = x * y; r = full & MASK; c = (full > MASK) ? 1 : 0; dly = N; end
            9:  if (s == 0) begin r = x; c = 0; end
                else begin r = (x << s) & MASK; c = (x >> (N - s)) & 1; dly = s; end
            10: if (s == 0) begin r = x; c = 0; end
                else begin r = x >> s; c = (x >> (s - 1)) & 1; dly = s; end
            default: ;
        endcase
        if (o <= 10) begin
            nc = (c != 0) ? 0 : 1;
            nz = (o == 7) ? ((x != y) ? 1 : 0) : ((r != 0) ? 1 : 0);
        end
    endtask

    // Entered and left just after a rising edge
    task automatic issue(input int o, input int x, input int y, input int nci_v);
        exp_t e;
        int bound;
        bound = 0;
        while (busy !== 1'b0 && bound < 50) begin
            start = 1'($urandom_range(0, 1));
            op    = 4'($urandom_range(0, 15));
            a_in  = N'($urandom_range(0, MASK));
            b_in  = N'($urandom_range(0, MASK));
            @(posedge clk); #1;
            bound++;
        end
        if (bound >= 50) begin
            n_vec++; n_fail++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, bound);
        end
        model(o, x, y, (nci_v != 0) ? 0 : 1, e.r, e.nc, e.nz, e.at);
        e.at = cyc + 1 + e.at;
        q.push_back(e);
        m_r = e.r; m_nc = e.nc; m_nz = e.nz;
        start = 1'b1;
        op    = 4'(o);
        a_in  = N'(x);
        b_in  = N'(y);
        nci   = 1'(nci_v);
        @(posedge clk); #1;
        start = 1'b0;
        op    = 4'($urandom_range(0, 15));
        a_in  = N'($urandom_range(0, MASK));
        b_in  = N'($urandom_range(0, MASK));
        nci   = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_notC"},   int'(notC),   1);
        check({tag, "_notZ"},   int'(notZ),   0);
        check({tag, "_busy"},   int'(busy),   0);
        check({tag, "_done"},   int'(done),   0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL spurious_done: got done=1 at cycle %0d, required no pending op", cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("result",     int'(result), mon_e.r);
                    check("notC",       int'(notC),   mon_e.nc);
                    check("notZ",       int'(notZ),   mon_e.nz);
                    check("done_cycle", cyc,          mon_e.at);
                    check("busy_in_done", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        int bound;
        reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; nci = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_reset_state("reset");

        issue(3, 9, 8, 1);
        issue(1, 3, 3, 1);
        issue(1, 2, 5, 1);
        issue(7, 5, 5, 1);
        issue(5, 15, 0, 0);
        issue(4, 5, 2, 1);

        issue(8, 7, 3, 1);
        check("mul_busy_0", int'(busy), 1);
        for (int i = 1; i < N; i++) begin
            start = 1'b1; op = 4'b0011; a_in = N'(i); b_in = N'(i);
            @(posedge clk); #1;
            check("mul_busy_hold", int'(busy), 1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("mul_busy_end", int'(busy), 0);

        issue(9, 3, 2, 1);
        issue(10, 9, 7, 1);
        issue(9, 5, 0, 1);
        issue(12, 6, 6, 1);
        idle(N + 2);

        issue(8, 13, 11, 1);
        reset = 1'b1;
        q.delete();
        m_r = 0; m_nc = 1; m_nz = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state("abort");
        idle(N + 4);

        for (int i = 0; i < 400; i++) begin
            int o, x, y, ci;
            o  = $urandom_range(0, 15);
            x  = $urandom_range(0, MASK);
            y  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, MASK) : $urandom_range(0, N + 1);
            ci = $urandom_range(0, 1);
            issue(o, x, y, ci);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        bound = 0;
        while (q.size() != 0 && bound < 100) begin
            @(posedge clk); #1;
            bound++;
        end
        check("drain", q.size(), 0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
